lfsr_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the 8-bit XNOR-feedback LFSR pattern generator. On `start` it clears the LFSR, steps it for a programmed number of patterns that drive the circuit-under-test (CUT), compacts the CUT responses in a MISR, and compares the final signature with a golden value. It sits between the test-access logic (start/abort/result) and the `lfsr` generator instance plus the CUT.

---
 rtl/lfsr_bist_pkg.sv | 34 +++
 rtl/lfsr_bist_misr.sv | 38 +++
 rtl/lfsr_bist_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lfsr_bist_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_bist_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_bist_pkg
// Shared definitions for the LFSR BIST sequencer:
//   - state_t      : controller state encoding
//   - MISR_TAPS    : feedback taps of the 8-bit signature register (7,5,4,3)
//   - DEFAULT_*    : default pattern/signature width and counter width
//   - misr_next()  : one MISR compaction step
// ---------------------------------------------------------------------------
package lfsr_bist_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 16;

  // Feedback taps of the MISR: bits 7, 5, 4 and 3.
  localparam logic [DEFAULT_WIDTH-1:0] MISR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Shift left, feed the tap parity into bit 0, then fold in the response.
  function automatic logic [DEFAULT_WIDTH-1:0] misr_next(
    input logic [DEFAULT_WIDTH-1:0] sig,
    input logic [DEFAULT_WIDTH-1:0] data
  );
    return {sig[DEFAULT_WIDTH-2:0], ^(sig & MISR_TAPS)} ^ data;
  endfunction

endpackage

// File: rtl/lfsr_bist_misr.sv
// ---------------------------------------------------------------------------
// lfsr_bist_misr
// Multiple-input signature register compacting CUT responses.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset (clears signature)
//   clear   in   synchronous clear to zero (wins over capture)
//   capture in   absorb `data` this cycle
//   data    in   WIDTH  CUT response
//   sig     out  WIDTH  current signature
// ---------------------------------------------------------------------------
module lfsr_bist_misr
  import lfsr_bist_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             capture,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  // Signature register: clear has priority, otherwise compact on capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= {WIDTH{1'b0}};
    end else if (clear) begin
      sig <= {WIDTH{1'b0}};
    end else if (capture) begin
      sig <= misr_next(sig, data);
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_bist_ctrl
// BIST sequencer: on start clears the external LFSR, steps it for N patterns,
// compacts the CUT responses in a MISR and compares against a golden value.
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   start, abort      run request (accepted in IDLE/DONE), run termination
//   pattern_count     number of patterns N, latched on accepted start
//   golden            expected signature, latched on accepted start
//   lfsr_out          current LFSR state (pattern applied to the CUT)
//   cut_resp          CUT response, valid one cycle after its pattern
//   lfsr_reset        synchronous clear to the LFSR (CLEAR state)
//   lfsr_enable       LFSR step enable (RUN state)
//   pattern_valid     CUT samples lfsr_out this cycle (RUN state)
//   busy              run in progress
//   done, pass        result valid / signature matched golden
//   signature         live MISR contents (only with LFSR_BIST_SIGNATURE_EN)
// Optional feature macro: LFSR_BIST_SIGNATURE_EN
// ---------------------------------------------------------------------------
module lfsr_bist_ctrl
  import lfsr_bist_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] pattern_count,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] lfsr_out,
  input  logic [WIDTH-1:0] cut_resp,
  output logic             lfsr_reset,
  output logic             lfsr_enable,
  output logic             pattern_valid,
  output logic             busy,
  output logic             done,
`ifdef LFSR_BIST_SIGNATURE_EN
  output logic             pass,
  output logic [WIDTH-1:0] signature
`else
  output logic             pass
`endif
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] golden_r;
  logic             capture_r;
  logic [WIDTH-1:0] sig_s;

  // The pattern goes straight from the generator to the CUT; the controller
  // only observes it, so it is folded into a deliberately unused net.
  logic lfsr_out_unused_s;
  assign lfsr_out_unused_s = ^lfsr_out;

  // Controller FSM with counter, golden latch and registered outputs.
  // Outputs are assigned from the state being entered, so they are valid
  // for the whole cycle spent in that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      golden_r      <= {WIDTH{1'b0}};
      lfsr_reset    <= 1'b0;
      lfsr_enable   <= 1'b0;
      pattern_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else if (abort) begin
      // Abort beats a simultaneous start and drops every enable at once.
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      golden_r      <= golden_r;
      lfsr_reset    <= 1'b0;
      lfsr_enable   <= 1'b0;
      pattern_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r    <= CLEAR;
            cnt_r      <= pattern_count;
            golden_r   <= golden;
            lfsr_reset <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end else begin
            state_r    <= state_r;
            cnt_r      <= cnt_r;
            golden_r   <= golden_r;
            lfsr_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= done;
            pass       <= pass;
          end
          lfsr_enable   <= 1'b0;
          pattern_valid <= 1'b0;
        end
        CLEAR: begin
          lfsr_reset <= 1'b0;
          if (cnt_r == CNT_ZERO) begin
            // Nothing to apply: the cleared MISR is compared directly.
            state_r       <= COMPARE;
            lfsr_enable   <= 1'b0;
            pattern_valid <= 1'b0;
          end else begin
            state_r       <= RUN;
            lfsr_enable   <= 1'b1;
            pattern_valid <= 1'b1;
          end
        end
        RUN: begin
          cnt_r <= cnt_r - CNT_ONE;
          // cnt_r == 1 means this is the last pattern cycle.
          if (cnt_r == CNT_ONE) begin
            state_r       <= DRAIN;
            lfsr_enable   <= 1'b0;
            pattern_valid <= 1'b0;
          end else begin
            state_r       <= RUN;
            lfsr_enable   <= 1'b1;
            pattern_valid <= 1'b1;
          end
        end
        DRAIN: begin
          // Last response is absorbed by the MISR during this cycle.
          state_r <= COMPARE;
        end
        COMPARE: begin
          state_r <= DONE;
          pass    <= (sig_s == golden_r);
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          cnt_r         <= CNT_ZERO;
          lfsr_reset    <= 1'b0;
          lfsr_enable   <= 1'b0;
          pattern_valid <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
          pass          <= 1'b0;
        end
      endcase
    end
  end

  // Capture flag: a pattern applied in cycle k yields its response in k+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_r <= 1'b0;
    end else begin
      capture_r <= pattern_valid;
    end
  end

  // The MISR is cleared during CLEAR, exactly when the LFSR is cleared.
  // No capture can occur in COMPARE or DONE, so the signature stays frozen
  // there until the next CLEAR.
  lfsr_bist_misr #(
    .WIDTH(WIDTH)
  ) u_misr (
    .clk    (clk),
    .reset  (reset),
    .clear  (lfsr_reset),
    .capture(capture_r),
    .data   (cut_resp),
    .sig    (sig_s)
  );

`ifdef LFSR_BIST_SIGNATURE_EN
  assign signature = sig_s;
`endif

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_bist_ctrl
// Self-checking bench: behavioural XNOR LFSR plus a registered identity CUT
// around lfsr_bist_ctrl. Expected results of each run are pushed to a
// scoreboard queue when start is driven and popped when done rises.
// ---------------------------------------------------------------------------
module tb_lfsr_bist_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] pattern_count;
  logic [7:0]  golden;
  logic [7:0]  lfsr_q;
  logic [7:0]  cut_q;
  logic        lfsr_reset;
  logic        lfsr_enable;
  logic        pattern_valid;
  logic        busy;
  logic        done;
  logic        pass;
`ifdef LFSR_BIST_SIGNATURE_EN
  logic [7:0]  signature;
`endif

  typedef struct packed {
    int         cyc;
    logic       pass;
    logic [7:0] sig;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt;
  int   miscompare_cnt;
  int   edge_cnt;
  int   e0;

  lfsr_bist_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .pattern_count(pattern_count),
    .golden       (golden),
    .lfsr_out     (lfsr_q),
    .cut_resp     (cut_q),
    .lfsr_reset   (lfsr_reset),
    .lfsr_enable  (lfsr_enable),
    .pattern_valid(pattern_valid),
    .busy         (busy),
    .done         (done),
`ifdef LFSR_BIST_SIGNATURE_EN
    .pass         (pass),
    .signature    (signature)
`else
    .pass         (pass)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] lfsr_model(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[3])};
  endfunction

  function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [7:0] d);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb} ^ d;
  endfunction

  // Pattern generator model with synchronous clear and step enable.
  always @(posedge clk or posedge reset) begin
    if (reset)            lfsr_q <= 8'h00;
    else if (lfsr_reset)  lfsr_q <= 8'h00;
    else if (lfsr_enable) lfsr_q <= lfsr_model(lfsr_q);
  end

  // Identity CUT: the response is the pattern, registered once.
  always @(posedge clk or posedge reset) begin
    if (reset) cut_q <= 8'h00;
    else       cut_q <= lfsr_q;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One full run: model the expected signature, push it, drive start and
  // wait (bounded) for done, then pop and compare.
  task automatic run_bist(input logic [15:0] n, input logic [7:0] gold);
    exp_t       e;
    logic [7:0] s;
    logic [7:0] p;
    int         pv_seen;
    int         budget;
    s = 8'h00;
    p = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      s = misr_model(s, p);
      p = lfsr_model(p);
    end
    e.cyc  = (n == 16'd0) ? 3 : int'(n) + 4;
    e.pass = (s == gold);
    e.sig  = s;
    sb_q.push_back(e);

    @(negedge clk);
    start = 1'b1; pattern_count = n; golden = gold;
    e0 = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    check_eq("clear_lfsr_reset", {31'd0, lfsr_reset}, 32'd1);
    check_eq("clear_busy_done", {30'd0, busy, done}, 32'd2);

    p = 8'h00;
    pv_seen = 0;
    budget = int'(n) + 20;
    while (!done && budget > 0) begin
      if (pattern_valid) begin
        if (pv_seen < 6) check_eq("pattern", {24'd0, lfsr_q}, {24'd0, p});
        p = lfsr_model(p);
        pv_seen++;
      end
      @(negedge clk);
      budget--;
    end
    e = sb_q.pop_front();
    if (!done) begin
      check_eq("done_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("done_cycle", edge_cnt - e0 + 1, e.cyc);
      check_eq("pass", {31'd0, pass}, {31'd0, e.pass});
      check_eq("pv_count", pv_seen, int'(n));
      check_eq("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef LFSR_BIST_SIGNATURE_EN
      check_eq("signature", {24'd0, signature}, {24'd0, e.sig});
`endif
    end
  endtask

  initial begin
    logic seen_reset;
    logic seen_busy;
    edge_cnt = 0;
    vec_cnt = 0;
    miscompare_cnt = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern_count = 16'd0; golden = 8'h00;
    #12;
    check_eq("reset_outputs",
             {26'd0, lfsr_reset, lfsr_enable, pattern_valid, busy, done, pass}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_bist(16'd1, 8'h00);     // pass, done in cycle 5
    run_bist(16'd3, 8'h01);     // pass (started from DONE)
    run_bist(16'd3, 8'h02);     // fail
    run_bist(16'd0, 8'h00);     // no patterns, done in cycle 3
    run_bist(16'd300, 8'h5A);   // beyond the LFSR period
    run_bist(16'd7, 8'h00);     // plain mismatch case

    // done/pass held, then cleared by abort in DONE.
    run_bist(16'd1, 8'h00);
    @(negedge clk);
    check_eq("done_held", {30'd0, done, pass}, 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_in_done", {30'd0, done, pass}, 32'd0);

    // N = 5: start in cycle 3 ignored, abort in cycle 4.
    @(negedge clk);
    start = 1'b1; pattern_count = 16'd5; golden = 8'h00;
    @(negedge clk); start = 1'b0;           // cycle 1
    @(negedge clk);                          // cycle 2
    @(negedge clk); start = 1'b1;           // cycle 3
    @(negedge clk); start = 1'b0; abort = 1'b1;  // cycle 4
    check_eq("busy_start_ignored", {30'd0, pattern_valid, lfsr_reset}, 32'd2);
    @(negedge clk); abort = 1'b0;           // cycle 5
    check_eq("abort_to_idle",
             {27'd0, lfsr_enable, pattern_valid, busy, done, pass}, 32'd0);
    @(negedge clk);
    check_eq("idle_after_abort", {30'd0, lfsr_reset, busy}, 32'd0);

    // start and abort together in IDLE: nothing happens.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    seen_reset = 1'b0;
    seen_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen_reset |= lfsr_reset;
      seen_busy |= busy;
      @(negedge clk);
    end
    check_eq("start_abort_idle", {30'd0, seen_reset, seen_busy}, 32'd0);

    // Reset mid-RUN clears outputs without a clock edge.
    start = 1'b1; pattern_count = 16'd5; golden = 8'h00;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_run_pv", {31'd0, pattern_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_reset",
             {26'd0, lfsr_reset, lfsr_enable, pattern_valid, busy, done, pass}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_bist(16'd3, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
